// File: rtl/expr_share_arb_if.sv
// Requester/response channel bundle for expr_share_arb: two request channels
// carrying operand bundles and two response channels sharing one result bus.
interface expr_share_arb_if #(
    parameter int OPW  = 60,
    parameter int RESW = 90
);
    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [OPW-1:0]  req0_ops;
    logic [OPW-1:0]  req1_ops;
    logic            rsp0_valid;
    logic            rsp1_valid;
    logic            rsp0_ready;
    logic            rsp1_ready;
    logic [RESW-1:0] rsp_y;

    modport master (
        output req0_valid, req1_valid, req0_ops, req1_ops, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y
    );

    modport slave (
        input  req0_valid, req1_valid, req0_ops, req1_ops, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_y
    );
endinterface

// File: rtl/expr_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational evaluator between two
// requesters. Optional macro EXPR_ARB_SETTLE_EN adds a SETTLE cycle before CAPTURE.
module expr_share_arb #(
    parameter int OPW  = 60,
    parameter int RESW = 90,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    expr_share_arb_if.slave      req_rsp,
    output logic [OPW-1:0]       ex_ops,
    input  logic [RESW-1:0]      ex_y,
    output logic                 busy,
    output logic [CNTW-1:0]      done_cnt,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
`ifdef EXPR_ARB_SETTLE_EN
        SETTLE  = 3'd2,
`endif
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [OPW-1:0]  op_q;
    logic [RESW-1:0] res_q;
    logic            gnt_q;
    logic            last_grant;
    logic            pick0;
    logic            pick1;
    logic            accept;
    logic            rsp_hs;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Valids never depend on readys; readys may follow valids combinationally.
    // A response valid holds, with rsp_y stable, until its ready is seen.
    always_comb begin
        pick0 = req_rsp.req0_valid && (!req_rsp.req1_valid || last_grant);
        pick1 = req_rsp.req1_valid && (!req_rsp.req0_valid || !last_grant);
    end

    assign accept = (state == IDLE) && (pick0 || pick1);
    assign rsp_hs = (state == RESP) && (gnt_q ? req_rsp.rsp1_ready : req_rsp.rsp0_ready);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
`ifdef EXPR_ARB_SETTLE_EN
            DRIVE:   state_nxt = SETTLE;
            SETTLE:  state_nxt = CAPTURE;
`else
            DRIVE:   state_nxt = CAPTURE;
`endif
            CAPTURE: state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_rsp.req0_ready = 1'b0;
        req_rsp.req1_ready = 1'b0;
        req_rsp.rsp0_valid = 1'b0;
        req_rsp.rsp1_valid = 1'b0;
        busy               = (state != IDLE);
        if (state == IDLE) begin
            req_rsp.req0_ready = pick0;
            req_rsp.req1_ready = pick1;
        end
        if (state == RESP) begin
            req_rsp.rsp0_valid = !gnt_q;
            req_rsp.rsp1_valid = gnt_q;
        end
    end

    // op_q only moves on accept, so the evaluator sees a fixed input from DRIVE to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            res_q      <= '0;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
            done_cnt   <= '0;
        end else begin
            if (accept) begin
                op_q       <= pick1 ? req_rsp.req1_ops : req_rsp.req0_ops;
                gnt_q      <= pick1;
                last_grant <= pick1;
            end
            if (state == CAPTURE) res_q <= ex_y;
            if (rsp_hs) done_cnt <= done_cnt + CNTW'(1);
        end
    end

    assign ex_ops        = op_q;
    assign req_rsp.rsp_y = res_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_expr_share_arb.sv
// Directed bench for expr_share_arb with a stand-in evaluator, an expected-result
// queue filled on accept and a monitor that pops it on every response handshake.
module tb_expr_share_arb;

    localparam int OPW  = 60;
    localparam int RESW = 90;
    localparam int CNTW = 8;
`ifdef EXPR_ARB_SETTLE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic            clk;
    logic            reset;
    logic [OPW-1:0]  ex_ops;
    logic [RESW-1:0] ex_y;
    logic            busy;
    logic [CNTW-1:0] done_cnt;
    logic [2:0]      state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [RESW:0] exp_q[$];

    expr_share_arb_if #(.OPW(OPW), .RESW(RESW)) arb_bus ();

    expr_share_arb #(.OPW(OPW), .RESW(RESW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_rsp   (arb_bus),
        .ex_ops    (ex_ops),
        .ex_y      (ex_y),
        .busy      (busy),
        .done_cnt  (done_cnt),
        .state_dbg (state_dbg)
    );

    // Stand-in evaluator: sum of the b and a halves above a scrambled copy of the operands.
    function automatic logic [RESW-1:0] eval(input logic [OPW-1:0] o);
        return {o[59:30] + o[29:0], o ^ 60'h0F0_F0F0_F0F0_F0F0};
    endfunction

    assign ex_y = eval(ex_ops);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input int idx, input logic [OPW-1:0] ops, input bit both, output int waited);
        logic got;
        @(posedge clk); #1;
        if (idx == 0) begin
            arb_bus.req0_ops   = ops;
            arb_bus.req0_valid = 1'b1;
            if (both) arb_bus.req1_valid = 1'b1;
        end else begin
            arb_bus.req1_ops   = ops;
            arb_bus.req1_valid = 1'b1;
            if (both) arb_bus.req0_valid = 1'b1;
        end
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 60) begin
            @(negedge clk);
            waited++;
            got = (idx == 0) ? arb_bus.req0_ready : arb_bus.req1_ready;
        end
        if (!got) begin
            fail_now("accept_timeout");
        end else begin
            check("other_ready_low", (idx == 0) ? arb_bus.req1_ready : arb_bus.req0_ready, 0);
            exp_q.push_back({idx[0], eval(ops)});
        end
        @(posedge clk); #1;
        if (idx == 0) arb_bus.req0_valid = 1'b0;
        else          arb_bus.req1_valid = 1'b0;
    endtask

    task automatic check_latency(input int idx, input logic [OPW-1:0] ops);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            check("ex_ops_stable", ex_ops, ops);
            check("rsp_valid_latency",
                  (idx == 0) ? arb_bus.rsp0_valid : arb_bus.rsp1_valid, (c == LAT) ? 1 : 0);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (c < 80) begin
            @(negedge clk);
            c++;
            if (exp_q.size() == 0 && !busy) break;
        end
        if (c >= 80) fail_now("drain_timeout");
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [RESW:0] e;
        if (arb_bus.rsp0_valid && arb_bus.rsp1_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL both_rsp_valid: got 1 expected 0");
        end
        if ((arb_bus.rsp0_valid && arb_bus.rsp0_ready) ||
            (arb_bus.rsp1_valid && arb_bus.rsp1_ready)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got idx %0d y %0h expected none",
                         arb_bus.rsp1_valid, arb_bus.rsp_y);
            end else begin
                e = exp_q.pop_front();
                check("rsp_idx_y", {arb_bus.rsp1_valid, arb_bus.rsp_y}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int cyc;
        int last_cyc;
        int accepts;
        int exp_idx;
        logic got;

        reset              = 1'b0;
        arb_bus.req0_valid = 1'b0;
        arb_bus.req1_valid = 1'b0;
        arb_bus.req0_ops   = '0;
        arb_bus.req1_ops   = '0;
        arb_bus.rsp0_ready = 1'b0;
        arb_bus.rsp1_ready = 1'b0;

        // Scenario 1: reset values, single request from requester 0
        do_reset();
        @(negedge clk);
        check("rst_req0_ready", arb_bus.req0_ready, 0);
        check("rst_req1_ready", arb_bus.req1_ready, 0);
        check("rst_rsp0_valid", arb_bus.rsp0_valid, 0);
        check("rst_rsp1_valid", arb_bus.rsp1_valid, 0);
        check("rst_rsp_y", arb_bus.rsp_y, 0);
        check("rst_ex_ops", ex_ops, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_state", state_dbg, 0);
        arb_bus.rsp0_ready = 1'b1;
        issue(0, 60'h0_0000_0001, 1'b0, w);
        check("t1_ready_same_cycle", w, 1);
        check_latency(0, 60'h0_0000_0001);
        drain();
        check("t1_done_cnt", done_cnt, 1);

        // Scenario 2: both requesters valid continuously, grants alternate
        do_reset();
        arb_bus.rsp0_ready = 1'b1;
        arb_bus.rsp1_ready = 1'b1;
        arb_bus.req0_ops   = 60'h123_4567_89AB_CDEF;
        arb_bus.req1_ops   = 60'hFED_CBA9_8765_4321;
        arb_bus.req0_valid = 1'b1;
        arb_bus.req1_valid = 1'b1;
        accepts  = 0;
        exp_idx  = 0;
        cyc      = 0;
        last_cyc = 0;
        while (accepts < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (arb_bus.req0_ready || arb_bus.req1_ready) begin
                got = arb_bus.req1_ready;
                check("t2_one_ready", arb_bus.req0_ready & arb_bus.req1_ready, 0);
                check("t2_grant_order", got, exp_idx);
                if (accepts > 0) check("t2_issue_interval", cyc - last_cyc, LAT + 1);
                last_cyc = cyc;
                exp_q.push_back({got, eval(got ? arb_bus.req1_ops : arb_bus.req0_ops)});
                accepts++;
                exp_idx ^= 1;
                @(posedge clk); #1;
                if (accepts == 4) begin
                    arb_bus.req0_valid = 1'b0;
                    arb_bus.req1_valid = 1'b0;
                end else if (got) begin
                    arb_bus.req1_ops = arb_bus.req1_ops + 60'h111_1111;
                end else begin
                    arb_bus.req0_ops = arb_bus.req0_ops ^ 60'h3C3_0000_00FF;
                end
            end
        end
        if (accepts < 4) fail_now("t2_accept_timeout");
        drain();
        check("t2_done_cnt", done_cnt, 4);

        // Scenario 3: requester 1 stalls its response for 10 cycles
        arb_bus.rsp0_ready = 1'b0;
        arb_bus.rsp1_ready = 1'b0;
        issue(1, 60'hA5A_5A5A_5A5A_5A5A, 1'b0, w);
        arb_bus.req0_ops   = 60'h000_0000_7777_0001;
        arb_bus.req0_valid = 1'b1;
        check_latency(1, 60'hA5A_5A5A_5A5A_5A5A);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            arb_bus.rsp0_ready = i[0];
            @(negedge clk);
            check("t3_rsp1_hold", arb_bus.rsp1_valid, 1);
            check("t3_rsp_y_hold", arb_bus.rsp_y, eval(60'hA5A_5A5A_5A5A_5A5A));
            check("t3_req0_ready_low", arb_bus.req0_ready, 0);
            check("t3_rsp0_valid_low", arb_bus.rsp0_valid, 0);
        end
        @(posedge clk); #1;
        arb_bus.rsp0_ready = 1'b0;
        arb_bus.rsp1_ready = 1'b1;
        arb_bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        arb_bus.rsp1_ready = 1'b0;
        check("t3_done_after_hs", done_cnt, 5);
        arb_bus.rsp0_ready = 1'b1;
        issue(0, 60'h000_0000_7777_0001, 1'b0, w);
        drain();
        check("t3_done_cnt", done_cnt, 6);

        // Scenario 4: reset in CAPTURE drops the transaction
        arb_bus.rsp0_ready = 1'b1;
        arb_bus.rsp1_ready = 1'b1;
        issue(0, 60'h0DE_AD00_BEEF_0042, 1'b0, w);
        repeat (LAT - 2) @(posedge clk);
        #1;
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("t4_in_capture", state_dbg, 3);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t4_rsp0_valid", arb_bus.rsp0_valid, 0);
        check("t4_rsp1_valid", arb_bus.rsp1_valid, 0);
        check("t4_done_cnt_rst", done_cnt, 0);
        check("t4_busy", busy, 0);
        check("t4_ex_ops", ex_ops, 0);
        check("t4_rsp_y", arb_bus.rsp_y, 0);
        arb_bus.req1_ops = 60'h246_8ACE_1357_9BDF;
        issue(0, 60'h0F0_0000_0000_000F, 1'b1, w);
        check("t4_req0_wins", w, 1);
        issue(1, 60'h246_8ACE_1357_9BDF, 1'b0, w);
        drain();
        check("t4_done_cnt", done_cnt, 2);

        // Scenario 5: completion counter wraps
        for (int i = 0; i < 253; i++) begin
            issue(0, {30'(i), 30'(i * 3 + 1)}, 1'b0, w);
            drain();
        end
        check("t5_done_ff", done_cnt, 8'hFF);
        issue(0, 60'h333_3333_3333_3333, 1'b0, w);
        drain();
        check("t5_done_wrap", done_cnt, 8'h00);

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
